// File: rtl/wb_port_arbiter_if.sv
// Write-back bus between the execute/memory stages and the GPR write port:
// ALU, LSU and MDU sources plus the registered register-file write outputs.
interface wb_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              alu_wr_en;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [REG_AW-1:0] mdu_rd;
  logic [XLEN-1:0]   mdu_data;
  logic              alu_stall;
  logic              gpr_wr_en;
  logic [REG_AW-1:0] gpr_wr_addr;
  logic [XLEN-1:0]   gpr_wr_data;
  logic              wb_err;

  modport slave (
    input  alu_wr_en, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output lsu_ready, mdu_ready, alu_stall,
    output gpr_wr_en, gpr_wr_addr, gpr_wr_data, wb_err
  );

  modport master (
    output alu_wr_en, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  lsu_ready, mdu_ready, alu_stall,
    input  gpr_wr_en, gpr_wr_addr, gpr_wr_data, wb_err
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// GPR write-port arbiter: ALU has fixed priority, LSU/MDU share the rest
// round-robin, and a starvation counter forces a one-cycle ALU stall.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic               risc_clk,
  input logic               risc_rst,
  wb_port_arbiter_if.slave  bus
);

  typedef enum logic {RUN, STALL} state_t;
  typedef enum logic {SRC_LSU, SRC_MDU} src_t;

  state_t           state;
  src_t             last_grant;
  logic [CNT_W-1:0] starve_cnt;

  logic alu_fire;
  logic lsu_grant;
  logic mdu_grant;
  logic lsu_fire;
  logic mdu_fire;
  logic waiting;
  logic starve;

  always_comb begin
    alu_fire  = bus.alu_wr_en && !bus.alu_stall;
    lsu_grant = bus.lsu_valid && (!bus.mdu_valid || last_grant == SRC_MDU);
    mdu_grant = bus.mdu_valid && (!bus.lsu_valid || last_grant == SRC_LSU);
    lsu_fire  = !risc_rst && !alu_fire && lsu_grant;
    mdu_fire  = !risc_rst && !alu_fire && mdu_grant;
    waiting   = (bus.lsu_valid && !lsu_fire) || (bus.mdu_valid && !mdu_fire);
    // Only RUN can trigger a stall, so stalls never occur back to back.
    starve    = (state == RUN) && waiting && !lsu_fire && !mdu_fire &&
                (starve_cnt == CNT_W'(STARVE_LIMIT - 1));
  end

  assign bus.lsu_ready = lsu_fire;
  assign bus.mdu_ready = mdu_fire;

  always_ff @(posedge risc_clk) begin
    if (risc_rst) begin
      state           <= RUN;
      last_grant      <= SRC_MDU;
      starve_cnt      <= '0;
      bus.alu_stall   <= 1'b0;
      bus.gpr_wr_en   <= 1'b0;
      bus.gpr_wr_addr <= '0;
      bus.gpr_wr_data <= '0;
      bus.wb_err      <= 1'b0;
    end else begin
      if (alu_fire) begin
        bus.gpr_wr_addr <= bus.alu_rd;
        bus.gpr_wr_data <= bus.alu_data;
        bus.gpr_wr_en   <= (bus.alu_rd != '0);
      end else if (lsu_fire) begin
        bus.gpr_wr_addr <= bus.lsu_rd;
        bus.gpr_wr_data <= bus.lsu_data;
        bus.gpr_wr_en   <= (bus.lsu_rd != '0);
      end else if (mdu_fire) begin
        bus.gpr_wr_addr <= bus.mdu_rd;
        bus.gpr_wr_data <= bus.mdu_data;
        bus.gpr_wr_en   <= (bus.mdu_rd != '0);
      end else begin
        bus.gpr_wr_en <= 1'b0;
      end

      if (lsu_fire)      last_grant <= SRC_LSU;
      else if (mdu_fire) last_grant <= SRC_MDU;

      if (lsu_fire || mdu_fire || !waiting || starve) starve_cnt <= '0;
      else                                            starve_cnt <= starve_cnt + 1'b1;

      if (bus.alu_wr_en && bus.alu_stall) bus.wb_err <= 1'b1;

      case (state)
        RUN: begin
          if (starve) begin
            state         <= STALL;
            bus.alu_stall <= 1'b1;
          end
        end
        STALL: begin
          state         <= RUN;
          bus.alu_stall <= 1'b0;
        end
        default: begin
          state         <= RUN;
          bus.alu_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected GPR writes go into a queue that
// a negedge monitor drains; handshake/stall/error flags are checked inline.
module tb_wb_port_arbiter;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  wb_port_arbiter #(
    .XLEN(XLEN), .REG_AW(REG_AW), .STARVE_LIMIT(4), .CNT_W(3)
  ) dut (
    .risc_clk(clk),
    .risc_rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [REG_AW-1:0] addr, input logic [XLEN-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ALU writes every cycle while LSU/MDU must keep waiting without a stall.
  task automatic alu_busy(input int n, input logic [REG_AW-1:0] rd0);
    for (int k = 0; k < n; k++) begin
      bus.alu_wr_en = 1'b1;
      bus.alu_rd    = rd0 + REG_AW'(k);
      bus.alu_data  = 32'hA000_0000 + 32'(rd0) * 32'h100 + 32'(k);
      #1;
      chk("busy_lsu_ready", 32'(bus.lsu_ready), 0);
      chk("busy_mdu_ready", 32'(bus.mdu_ready), 0);
      chk("busy_alu_stall", 32'(bus.alu_stall), 0);
      push(bus.alu_rd, bus.alu_data);
      step();
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.gpr_wr_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got r%0d=%h expected no write",
                 bus.gpr_wr_addr, bus.gpr_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.gpr_wr_addr !== e.addr || bus.gpr_wr_data !== e.data) begin
          miscompares++;
          $display("FAIL gpr_write: got r%0d=%h expected r%0d=%h",
                   bus.gpr_wr_addr, bus.gpr_wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    bus.alu_wr_en = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;

    // Reset state; readies held low while reset is asserted.
    repeat (2) step();
    bus.lsu_valid = 1'b1; bus.mdu_valid = 1'b1;
    #1;
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 0);
    chk("rst_mdu_ready", 32'(bus.mdu_ready), 0);
    chk("rst_alu_stall", 32'(bus.alu_stall), 0);
    chk("rst_gpr_wr_en", 32'(bus.gpr_wr_en), 0);
    chk("rst_gpr_addr", 32'(bus.gpr_wr_addr), 0);
    chk("rst_gpr_data", bus.gpr_wr_data, 0);
    chk("rst_wb_err", 32'(bus.wb_err), 0);
    bus.lsu_valid = 1'b0; bus.mdu_valid = 1'b0;
    rst = 1'b0;
    step();

    // ALU only, then an x0 write that is consumed but not written.
    bus.alu_wr_en = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    push(5'd5, 32'hDEAD_BEEF);
    step();
    bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_1234;
    chk("alu_wr_en", 32'(bus.gpr_wr_en), 1);
    chk("alu_addr", 32'(bus.gpr_wr_addr), 5);
    chk("alu_data", bus.gpr_wr_data, 32'hDEAD_BEEF);
    step();
    bus.alu_wr_en = 1'b0;
    chk("x0_wr_en", 32'(bus.gpr_wr_en), 0);
    step();
    chk("idle_wr_en", 32'(bus.gpr_wr_en), 0);
    chk("idle_hold_addr", 32'(bus.gpr_wr_addr), 0);
    chk("idle_hold_data", bus.gpr_wr_data, 32'h0000_1234);

    // Round-robin after reset: LSU first, then MDU, then LSU again.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h0000_0AAA;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd4; bus.mdu_data = 32'h0000_0BBB;
    #1;
    chk("rr0_lsu_ready", 32'(bus.lsu_ready), 1);
    chk("rr0_mdu_ready", 32'(bus.mdu_ready), 0);
    push(5'd3, 32'h0000_0AAA);
    step();
    bus.lsu_rd = 5'd6; bus.lsu_data = 32'h0000_0CCC;
    #1;
    chk("rr1_lsu_ready", 32'(bus.lsu_ready), 0);
    chk("rr1_mdu_ready", 32'(bus.mdu_ready), 1);
    chk("rr1_gpr_addr", 32'(bus.gpr_wr_addr), 3);
    push(5'd4, 32'h0000_0BBB);
    step();
    bus.mdu_valid = 1'b0;
    #1;
    chk("rr2_lsu_ready", 32'(bus.lsu_ready), 1);
    chk("rr2_gpr_addr", 32'(bus.gpr_wr_addr), 4);
    push(5'd6, 32'h0000_0CCC);
    step();
    bus.lsu_valid = 1'b0;
    step();

    // Starvation: LSU waits 4 cycles, stall on cycle 4 serves it.
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0055;
    alu_busy(4, 5'd10);
    chk("starve_alu_stall", 32'(bus.alu_stall), 1);
    bus.alu_wr_en = 1'b0;
    #1;
    chk("starve_lsu_ready", 32'(bus.lsu_ready), 1);
    push(5'd7, 32'h0000_0055);
    step();
    bus.lsu_valid = 1'b0;
    chk("starve_stall_clear", 32'(bus.alu_stall), 0);
    chk("starve_gpr_addr", 32'(bus.gpr_wr_addr), 7);
    chk("starve_gpr_data", bus.gpr_wr_data, 32'h0000_0055);
    bus.alu_wr_en = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h0000_0011;
    push(5'd1, 32'h0000_0011);
    step();

    // Both waiting: stall grants MDU (LSU won last), LSU needs a second stall.
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'h0000_1200;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd13; bus.mdu_data = 32'h0000_1300;
    alu_busy(4, 5'd16);
    chk("both_stall1", 32'(bus.alu_stall), 1);
    bus.alu_wr_en = 1'b0;
    #1;
    chk("both_stall1_mdu_ready", 32'(bus.mdu_ready), 1);
    chk("both_stall1_lsu_ready", 32'(bus.lsu_ready), 0);
    push(5'd13, 32'h0000_1300);
    step();
    bus.mdu_valid = 1'b0;
    alu_busy(4, 5'd20);
    chk("both_stall2", 32'(bus.alu_stall), 1);
    bus.alu_wr_en = 1'b0;
    #1;
    chk("both_stall2_lsu_ready", 32'(bus.lsu_ready), 1);
    push(5'd12, 32'h0000_1200);
    step();
    bus.lsu_valid = 1'b0;
    step();

    // Protocol error: ALU writes during the stall cycle and is dropped.
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd8; bus.lsu_data = 32'h0000_0077;
    alu_busy(4, 5'd24);
    chk("perr_alu_stall", 32'(bus.alu_stall), 1);
    chk("perr_wb_err_before", 32'(bus.wb_err), 0);
    bus.alu_wr_en = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_0BAD;
    #1;
    chk("perr_lsu_ready", 32'(bus.lsu_ready), 1);
    push(5'd8, 32'h0000_0077);
    step();
    bus.alu_wr_en = 1'b0; bus.lsu_valid = 1'b0;
    chk("perr_wb_err_set", 32'(bus.wb_err), 1);
    chk("perr_gpr_addr", 32'(bus.gpr_wr_addr), 8);
    chk("perr_gpr_data", bus.gpr_wr_data, 32'h0000_0077);
    step();
    chk("perr_wb_err_sticky", 32'(bus.wb_err), 1);
    step();

    // Reset mid-wait: counter restarts, LSU stays pending and is served later.
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd14; bus.lsu_data = 32'h0000_00E0;
    alu_busy(3, 5'd2);
    rst = 1'b1;
    bus.alu_wr_en = 1'b1; bus.alu_rd = 5'd30; bus.alu_data = 32'h0000_0F0F;
    #1;
    chk("midrst_lsu_ready", 32'(bus.lsu_ready), 0);
    step();
    rst = 1'b0;
    chk("midrst_alu_stall", 32'(bus.alu_stall), 0);
    chk("midrst_gpr_wr_en", 32'(bus.gpr_wr_en), 0);
    chk("midrst_gpr_addr", 32'(bus.gpr_wr_addr), 0);
    chk("midrst_gpr_data", bus.gpr_wr_data, 0);
    chk("midrst_wb_err", 32'(bus.wb_err), 0);
    alu_busy(4, 5'd2);
    chk("midrst_stall", 32'(bus.alu_stall), 1);
    bus.alu_wr_en = 1'b0;
    #1;
    chk("midrst_lsu_served", 32'(bus.lsu_ready), 1);
    push(5'd14, 32'h0000_00E0);
    step();
    bus.lsu_valid = 1'b0;
    step();

    // LSU held through a reset pulse is granted on the first free cycle after.
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd15; bus.lsu_data = 32'h0000_00F0;
    rst = 1'b1;
    #1;
    chk("rstpulse_lsu_ready", 32'(bus.lsu_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("postrst_lsu_ready", 32'(bus.lsu_ready), 1);
    push(5'd15, 32'h0000_00F0);
    step();
    bus.lsu_valid = 1'b0;

    repeat (3) step();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single GPR write port among three write-back sources: the ALU pipeline result, the load/store unit (LSU) load data and the multiply/divide unit (MDU) result.
- Sits between the execute/memory stages and the register-file write port.
- The ALU has fixed top priority and no backpressure. LSU and MDU use valid/ready and are served round-robin.
- A starvation counter inserts a one-cycle ALU stall so that a waiting LSU/MDU result is guaranteed forward progress.

Parameters:
- XLEN, 32, data width of write-back values.
- REG_AW, 5, register address width.
- STARVE_LIMIT, 4, consecutive wait cycles tolerated before an ALU stall is forced (legal range 1..2^CNT_W-1).
- CNT_W, 3, width of the starvation counter.

Ports:
- risc_clk  in  1  core clock.
- risc_rst  in  1  synchronous active-high reset.
- alu_wr_en  in  1  ALU result wants write-back this cycle.
- alu_rd  in  REG_AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load result pending.
- lsu_ready  out  1  load result accepted this cycle.
- lsu_rd  in  REG_AW  load destination register.
- lsu_data  in  XLEN  load data.
- mdu_valid  in  1  MDU result pending.
- mdu_ready  out  1  MDU result accepted this cycle.
- mdu_rd  in  REG_AW  MDU destination register.
- mdu_data  in  XLEN  MDU result.
- alu_stall  out  1  registered; ALU must not present alu_wr_en in this cycle.
- gpr_wr_en  out  1  registered register-file write enable.
- gpr_wr_addr  out  REG_AW  registered write address.
- gpr_wr_data  out  XLEN  registered write data.
- wb_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (risc_rst high at an edge):
  - alu_stall, gpr_wr_en, gpr_wr_addr, gpr_wr_data and wb_err go to 0.
  - Starvation counter goes to 0.
  - RR pointer is set to last_grant = MDU, so LSU wins the first tie.
  - lsu_ready and mdu_ready are forced low combinationally while risc_rst is high.
  - Reset mid-wait drops no request: valids stay held and are served after reset.
- Grant, combinational each cycle:
  - alu_wr_en && !alu_stall: ALU wins; lsu_ready = mdu_ready = 0.
  - Otherwise, if exactly one of lsu_valid/mdu_valid is high, it wins.
  - If both are high, the one not equal to last_grant wins.
  - ready = valid && granted. last_grant updates on every LSU/MDU fire (valid && ready).
- Source handshake: once valid rises, rd and data stay stable until ready. A fire consumes the request in the same cycle.
- Write output, 1-cycle latency:
  - At the edge after a fire (ALU, LSU or MDU), gpr_wr_addr and gpr_wr_data take the winner's rd/data.
  - gpr_wr_en = 1 only if rd != 0. An x0 write is consumed but never written.
  - With no fire, gpr_wr_en = 0 and addr/data hold their last values.
- Starvation counter:
  - Define waiting = (lsu_valid && !lsu_ready) || (mdu_valid && !mdu_ready).
  - Any LSU/MDU fire clears the counter to 0.
  - Otherwise, waiting increments the counter.
  - Otherwise (nothing waiting), the counter clears to 0.
  - When waiting is true, there is no fire and the counter equals STARVE_LIMIT-1, the next edge sets alu_stall = 1 and clears the counter.
- Stall state machine: two states, RUN and STALL.
  - RUN: alu_stall = 0. Moves to STALL on the starvation condition above.
  - STALL: alu_stall = 1 for exactly one cycle, then always returns to RUN.
  - In STALL, ALU priority is disabled and LSU/MDU is granted by round-robin.
  - A stall is never issued on two consecutive cycles.
- Protocol error: alu_wr_en high while alu_stall is high sets wb_err (sticky until reset). That ALU write is dropped, not performed.
- Simultaneous events:
  - ALU and both units valid: ALU is written. LSU and MDU both wait and both count toward one shared counter.
  - After a stall serves one unit, the other is served on the next free cycle, or by a new stall after STARVE_LIMIT further waits.
- Throughput: at most one GPR write per cycle; no combinational path from inputs to gpr_* outputs.

Test Plan:
- ALU only: alu_wr_en=1, alu_rd=5, alu_data=32'hDEAD_BEEF -> next cycle gpr_wr_en=1, addr=5, data=DEADBEEF. Then alu_rd=0 -> gpr_wr_en=0.
- Round-robin after reset: lsu_valid and mdu_valid both held with no ALU traffic -> cycle0 lsu_ready=1; cycle1 mdu_ready=1; writes appear on cycles 1 and 2 in LSU, MDU order.
- Starvation: alu_wr_en=1 every cycle, lsu_valid=1 (rd=7, data=0x55) from cycle0, STARVE_LIMIT=4.
  - lsu_ready=0 on cycles 0-3; alu_stall=1 on cycle 4 with lsu_ready=1 on cycle 4.
  - gpr write of r7=0x55 on cycle 5; alu_stall=0 on cycle 5.
- Protocol error: drive alu_wr_en=1 during the alu_stall cycle -> wb_err=1 next cycle and stays set; no write of the ALU value occurs.
- Reset mid-wait: lsu_valid held, risc_rst pulsed on cycle 2 -> all outputs 0 next cycle, counter restarts; LSU is granted on the first cycle after reset release when there is no ALU traffic.
